// File: rtl/aes_core_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : aes_core_scheduler
// Description : Arbitrates NUM_REQ requesters onto one shared AES core and
//               returns each ciphertext (or a timeout error) tagged with the
//               requester index. Define AES_SCHED_FIXED_PRIO_EN for fixed
//               lowest-index priority instead of round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_core_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int TIMEOUT    = 64,
    parameter int GAP_CYCLES = 2,
    localparam int IDW       = $clog2(NUM_REQ)
) (
    input  logic                   AES_clk,
    input  logic                   AES_rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*128-1:0] req_data,
    input  logic [NUM_REQ*128-1:0] req_key,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [127:0]           rsp_data,
    output logic [IDW-1:0]         rsp_id,
    output logic                   rsp_err,
    output logic                   core_en,
    output logic [127:0]           core_data_in,
    output logic [127:0]           core_key_in,
    input  logic [127:0]           core_data_out,
    input  logic                   core_out_valid
);

    localparam int c_RUN_W = $clog2(TIMEOUT);
    localparam int c_GAP_W = $clog2(GAP_CYCLES + 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;
    localparam logic [1:0] c_GAP  = 2'd3;

    localparam logic [c_RUN_W-1:0] c_RUN_LAST = c_RUN_W'(TIMEOUT - 1);
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(GAP_CYCLES - 1);

    logic [1:0]           r_state;
    logic [IDW-1:0]       r_last_grant;
    logic [c_RUN_W-1:0]   r_run_cnt;
    logic [c_GAP_W-1:0]   r_gap_cnt;
    logic [NUM_REQ-1:0]   r_req_ready;
    logic                 r_rsp_valid;
    logic [127:0]         r_rsp_data;
    logic [IDW-1:0]       r_rsp_id;
    logic                 r_rsp_err;
    logic                 r_core_en;
    logic [127:0]         r_core_data_in;
    logic [127:0]         r_core_key_in;

    logic                 w_any;
    logic [IDW-1:0]       w_grant;
    logic [NUM_REQ-1:0]   w_grant_onehot;

`ifdef AES_SCHED_FIXED_PRIO_EN
    // Descending scan so the lowest requesting index is the last one written.
    always_comb begin
        w_any   = 1'b0;
        w_grant = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                w_any   = 1'b1;
                w_grant = IDW'(i);
            end
        end
    end
`else
    function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] base, input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return IDW'(sum);
    endfunction

    // Offsets scanned high to low: the nearest requester after last_grant wins,
    // last_grant itself is considered last.
    always_comb begin
        w_any   = 1'b0;
        w_grant = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req_valid[rr_index(r_last_grant, k)]) begin
                w_any   = 1'b1;
                w_grant = rr_index(r_last_grant, k);
            end
        end
    end
`endif

    always_comb begin
        w_grant_onehot          = '0;
        w_grant_onehot[w_grant] = 1'b1;
    end

    always_ff @(posedge AES_clk) begin
        if (AES_rst) begin
            r_state        <= c_IDLE;
            r_last_grant   <= IDW'(NUM_REQ - 1);
            r_run_cnt      <= '0;
            r_gap_cnt      <= '0;
            r_req_ready    <= '0;
            r_rsp_valid    <= 1'b0;
            r_rsp_data     <= '0;
            r_rsp_id       <= '0;
            r_rsp_err      <= 1'b0;
            r_core_en      <= 1'b0;
            r_core_data_in <= '0;
            r_core_key_in  <= '0;
        end else begin
            r_req_ready <= '0;
            case (r_state)
                c_IDLE: begin
                    if (w_any) begin
                        r_req_ready    <= w_grant_onehot;
                        r_core_data_in <= req_data[w_grant*128 +: 128];
                        r_core_key_in  <= req_key[w_grant*128 +: 128];
                        r_rsp_id       <= w_grant;
                        r_last_grant   <= w_grant;
                        r_core_en      <= 1'b1;
                        r_run_cnt      <= '0;
                        r_state        <= c_RUN;
                    end
                end
                c_RUN: begin
                    // A valid on the final timeout cycle still counts as success.
                    if (core_out_valid) begin
                        r_rsp_data  <= core_data_out;
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_core_en   <= 1'b0;
                        r_state     <= c_RESP;
                    end else if (r_run_cnt == c_RUN_LAST) begin
                        r_rsp_data  <= '0;
                        r_rsp_err   <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_core_en   <= 1'b0;
                        r_state     <= c_RESP;
                    end else begin
                        r_run_cnt <= r_run_cnt + 1'b1;
                    end
                end
                c_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_gap_cnt   <= '0;
                        r_state     <= c_GAP;
                    end
                end
                c_GAP: begin
                    // Holding core_en low lets the core drop its previous job.
                    if (r_gap_cnt == c_GAP_LAST) begin
                        r_state <= c_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign req_ready    = r_req_ready;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_data     = r_rsp_data;
    assign rsp_id       = r_rsp_id;
    assign rsp_err      = r_rsp_err;
    assign core_en      = r_core_en;
    assign core_data_in = r_core_data_in;
    assign core_key_in  = r_core_key_in;

endmodule
`default_nettype wire

// File: tb/tb_aes_core_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_core_scheduler
// Description : Self-checking bench for aes_core_scheduler with a behavioural
//               core model (programmable latency, optional hang, stray valids).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_core_scheduler;

    localparam int NUM_REQ    = 4;
    localparam int TIMEOUT    = 64;
    localparam int GAP_CYCLES = 2;

    localparam logic [127:0] KAT_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KAT_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KAT_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic                   AES_clk = 1'b0;
    logic                   AES_rst;
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ*128-1:0] req_data;
    logic [NUM_REQ*128-1:0] req_key;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [127:0]           rsp_data;
    logic [1:0]             rsp_id;
    logic                   rsp_err;
    logic                   core_en;
    logic [127:0]           core_data_in;
    logic [127:0]           core_key_in;
    logic [127:0]           core_data_out;
    logic                   core_out_valid;

    int errors = 0;
    int checks = 0;

    int           stub_lat = 1000;
    bit           stray_en = 1'b0;
    int           stub_cnt = 0;
    int           model_last = NUM_REQ - 1;
    int           last_g;
    logic [127:0] last_rsp;
    logic [127:0] pt [NUM_REQ];
    logic [127:0] ky [NUM_REQ];

    always #5 AES_clk = ~AES_clk;

    aes_core_scheduler #(
        .NUM_REQ    (NUM_REQ),
        .TIMEOUT    (TIMEOUT),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .AES_clk        (AES_clk),
        .AES_rst        (AES_rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_data       (req_data),
        .req_key        (req_key),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_data       (rsp_data),
        .rsp_id         (rsp_id),
        .rsp_err        (rsp_err),
        .core_en        (core_en),
        .core_data_in   (core_data_in),
        .core_key_in    (core_key_in),
        .core_data_out  (core_data_out),
        .core_out_valid (core_out_valid)
    );

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Stand-in cipher: exact AES result for the known-answer vector, a keyed mix otherwise.
    function automatic logic [127:0] core_fn(input logic [127:0] d, input logic [127:0] k);
        if (d == KAT_PT && k == KAT_KEY) begin
            return KAT_CT;
        end
        return (d ^ {k[63:0], k[127:64]}) + 128'h9e3779b97f4a7c15f39cc0605cedc834;
    endfunction

    // Core model: valid in the stub_lat-th enabled cycle; random stray valids while disabled.
    always @(negedge AES_clk) begin
        if (core_en === 1'b1) begin
            stub_cnt       = stub_cnt + 1;
            core_out_valid = (stub_cnt == stub_lat);
            core_data_out  = core_out_valid ? core_fn(core_data_in, core_key_in) : rand128();
        end else begin
            stub_cnt       = 0;
            core_out_valid = stray_en && ($urandom_range(0, 2) == 0);
            core_data_out  = rand128();
        end
    end

    function automatic int model_grant(input logic [NUM_REQ-1:0] m);
`ifdef AES_SCHED_FIXED_PRIO_EN
        for (int i = 0; i < NUM_REQ; i++) begin
            if (m[i]) return i;
        end
`else
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (m[(model_last + k) % NUM_REQ]) return (model_last + k) % NUM_REQ;
        end
`endif
        return -1;
    endfunction

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_reset(input int cycles);
        AES_rst   = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        repeat (cycles) @(negedge AES_clk);
        check("reset_outputs",
              {req_ready, rsp_valid, rsp_data, rsp_id, rsp_err, core_en, core_data_in, core_key_in},
              '0);
        AES_rst    = 1'b0;
        model_last = NUM_REQ - 1;
    endtask

    // One complete job: present requests, expect the model's grant, time the core phase,
    // check the response, apply backpressure, then handshake.
    task automatic do_job(input logic [NUM_REQ-1:0] vmask, input logic [NUM_REQ-1:0] keep,
                          input int lat, input int hold, input bit use_kat, output int wait_cnt);
        int           g;
        int           en_cnt;
        int           n;
        bit           en_bad;
        bit           pulse_bad;
        bit           bp_bad;
        logic [127:0] exp_data;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (vmask[i]) begin
                pt[i] = (use_kat && i == 0) ? KAT_PT : rand128();
                ky[i] = (use_kat && i == 0) ? KAT_KEY : rand128();
                req_data[i*128 +: 128] = pt[i];
                req_key[i*128 +: 128]  = ky[i];
            end
        end
        req_valid = vmask;
        stub_lat  = lat;
        g         = model_grant(vmask);
        wait_cnt  = 0;
        en_bad    = 1'b0;
        while (req_ready === '0 && wait_cnt < 50) begin
            if (core_en !== 1'b0) en_bad = 1'b1;
            @(negedge AES_clk);
            wait_cnt++;
        end
        check("core_en_low_before_grant", en_bad, 1'b0);
        check("grant_onehot", req_ready, NUM_REQ'(1) << g);
        check("core_inputs", {core_data_in, core_key_in}, {pt[g], ky[g]});
        last_g     = g;
        model_last = g;
        if (!keep[g]) req_valid[g] = 1'b0;

        en_cnt    = (core_en === 1'b1) ? 1 : 0;
        pulse_bad = 1'b0;
        n         = 0;
        while (n < 200) begin
            @(negedge AES_clk);
            n++;
            if (req_ready !== '0) pulse_bad = 1'b1;
            if (rsp_valid === 1'b1) break;
            if (core_en === 1'b1) en_cnt++;
        end
        check("ready_single_cycle", pulse_bad, 1'b0);
        check("rsp_valid_seen", rsp_valid, 1'b1);
        check("core_en_cycles", en_cnt, (lat <= TIMEOUT) ? lat : TIMEOUT);
        exp_data = (lat <= TIMEOUT) ? core_fn(pt[g], ky[g]) : 128'h0;
        check("rsp_fields", {rsp_data, rsp_id, rsp_err, core_en},
              {exp_data, 2'(g), (lat > TIMEOUT), 1'b0});
        last_rsp = rsp_data;

        bp_bad = 1'b0;
        for (int h = 0; h < hold; h++) begin
            @(negedge AES_clk);
            if ({rsp_valid, rsp_data, rsp_id, rsp_err, core_en, req_ready} !==
                {1'b1, exp_data, 2'(g), (lat > TIMEOUT), 1'b0, 4'b0}) bp_bad = 1'b1;
        end
        check("backpressure_stable", bp_bad, 1'b0);
        rsp_ready = 1'b1;
        @(negedge AES_clk);
        rsp_ready = 1'b0;
        check("rsp_valid_drop", {rsp_valid, core_en}, 2'b00);
    endtask

    initial begin
        int w;
        int exp_seq [5];
        logic [NUM_REQ-1:0] m;

        // Reset and idle behaviour
        core_out_valid = 1'b0;
        core_data_out  = '0;
        req_data       = '0;
        req_key        = '0;
        apply_reset(3);
        m = '0;
        repeat (6) begin
            @(negedge AES_clk);
            m = m | req_ready | {3'b0, core_en};
        end
        check("idle_quiet", m, '0);

        // Known-answer job on requester 0
        do_job(4'b0001, 4'b0000, 12, 0, 1'b1, w);
        check("kat_ciphertext", last_rsp, KAT_CT);

        // All four held: arbitration order
        apply_reset(3);
        for (int j = 0; j < 5; j++) begin
`ifdef AES_SCHED_FIXED_PRIO_EN
            exp_seq[j] = 0;
`else
            exp_seq[j] = j % NUM_REQ;
`endif
            do_job(4'b1111, 4'b1111, $urandom_range(3, 10), 0, 1'b0, w);
            check("grant_sequence", last_g, exp_seq[j]);
        end
        req_valid = '0;

        // Long backpressure, then gap length before the already-pending next job
        do_job(4'b0010, 4'b0000, 5, 20, 1'b0, w);
        do_job(4'b1000, 4'b0000, 4, 0, 1'b0, w);
        check("gap_then_arbitration_cycles", w, GAP_CYCLES + 1);

        // Timeout boundaries
        do_job(4'b0001, 4'b0000, 1000, 2, 1'b0, w);
        do_job(4'b0010, 4'b0000, TIMEOUT, 0, 1'b0, w);
        do_job(4'b0100, 4'b0000, TIMEOUT + 1, 0, 1'b0, w);

        // Reset in the middle of a job
        stub_lat  = 1000;
        req_data[2*128 +: 128] = rand128();
        req_key[2*128 +: 128]  = rand128();
        req_valid = 4'b0100;
        w = 0;
        while (req_ready === '0 && w < 50) begin
            @(negedge AES_clk);
            w++;
        end
        check("midrun_accept", req_ready, 4'b0100);
        req_valid = '0;
        repeat (5) @(negedge AES_clk);
        AES_rst = 1'b1;
        @(negedge AES_clk);
        check("midrun_reset", {core_en, rsp_valid, req_ready}, '0);
        AES_rst    = 1'b0;
        model_last = NUM_REQ - 1;
        do_job(4'b0010, 4'b0000, 7, 1, 1'b0, w);
        check("post_reset_grant", last_g, 1);

        // Randomised jobs with stray core valids outside the run phase
        stray_en = 1'b1;
        for (int j = 0; j < 12; j++) begin
            m = NUM_REQ'($urandom_range(1, 15));
            do_job(m, NUM_REQ'($urandom_range(0, 15)), $urandom_range(1, 20),
                   $urandom_range(0, 3), 1'b0, w);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
